rep3_tx: RTL and testbench

Serial transmitter for the triple-repetition line code; the 3-input majority voter is the decision element at the receiving end. Accepts a parallel word on a valid/ready handshake and frames it as start bit, DATA_W data bits (LSB first), stop bit. Every frame bit is sent as 3 identical chips, each held for CLKS_PER_CHIP clocks. It feeds the serial link that the receive-side voter samples, one chip per voter input.

---
 rtl/rep3_pkg.sv | 17 +
 rtl/rep3_chip_timer.sv | 42 ++++
 rtl/rep3_tx.sv | 134 +++++++++++++
 tb/tb_rep3_tx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rep3_pkg.sv
// Shared types and line-code constants for the triple-repetition transmitter.
package rep3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int REP = 3;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/rep3_chip_timer.sv
// Chip timing: a clock divider whose wrap is the chip strobe, plus a chip counter
// that marks the last of the REP chips making up one frame bit.
module rep3_chip_timer
    import rep3_pkg::*;
#(
    parameter int CLKS_PER_CHIP = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_chip_stb,
    output logic o_bit_end
);

    localparam int               DIV_W     = (CLKS_PER_CHIP > 1) ? $clog2(CLKS_PER_CHIP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_CHIP - 1);
    localparam logic [1:0]       CHIP_LAST = 2'(REP - 1);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_chip;

    assign o_chip_stb = i_run && (r_div == DIV_LAST);
    // Level, not pulse: the current chip is the last one of the frame bit.
    assign o_bit_end  = (r_chip == CHIP_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_chip <= '0;
        end else if (i_clear) begin
            r_div  <= '0;
            r_chip <= '0;
        end else if (o_chip_stb) begin
            r_div  <= '0;
            r_chip <= (r_chip == CHIP_LAST) ? 2'd0 : r_chip + 2'd1;
        end else if (i_run) begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/rep3_tx.sv
// Triple-repetition serial transmitter: frames a parallel word as start, DATA_W
// data bits LSB first, stop, and sends every frame bit as REP identical chips.
module rep3_tx
    import rep3_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CLKS_PER_CHIP = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] DIN,
    input  logic              VALID,
    output logic              READY,
    output logic              TXD,
    output logic              BUSY,
    output logic              DONE
);

    localparam int               IDX_W    = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
        $error("rep3_tx: DATA_W must be in 1..16");
    end
    if (CLKS_PER_CHIP < 1 || CLKS_PER_CHIP > 1024) begin : g_bad_clks_per_chip
        $error("rep3_tx: CLKS_PER_CHIP must be in 1..1024");
    end

    tx_state_t         r_state,   w_state_nxt;
    logic [DATA_W-1:0] r_shift,   w_shift_nxt;
    logic [IDX_W-1:0]  r_bit_idx, w_bit_idx_nxt;
    logic              r_txd,     w_txd_nxt;
    logic              r_busy,    w_busy_nxt;
    logic              r_done,    w_done_nxt;
    logic [DATA_W-1:0] w_shift_dn;
    logic              w_hs;
    logic              w_run;
    logic              w_chip_stb;
    logic              w_bit_end;
    logic              w_bit_done;

    assign w_run      = (r_state != IDLE);
    assign w_bit_done = w_chip_stb && w_bit_end;
    assign w_shift_dn = r_shift >> 1;

    rep3_chip_timer #(
        .CLKS_PER_CHIP(CLKS_PER_CHIP)
    ) u_timer (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_clear    (w_hs),
        .i_run      (w_run),
        .o_chip_stb (w_chip_stb),
        .o_bit_end  (w_bit_end)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_txd_nxt     = r_txd;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_hs          = 1'b0;

        case (r_state)
            IDLE: begin
                w_txd_nxt  = IDLE_LVL;
                w_busy_nxt = 1'b0;
                if (VALID) begin
                    w_hs          = 1'b1;
                    w_shift_nxt   = DIN;
                    w_bit_idx_nxt = '0;
                    w_txd_nxt     = START_LVL;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_txd_nxt   = r_shift[0];
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_shift_nxt   = w_shift_dn;
                    w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    if (r_bit_idx == LAST_IDX) begin
                        w_txd_nxt   = STOP_LVL;
                        w_state_nxt = STOP;
                    end else begin
                        w_txd_nxt   = w_shift_dn[0];
                    end
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_txd_nxt   = IDLE_LVL;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_txd     <= IDLE_LVL;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign READY = (r_state == IDLE);
    assign TXD   = r_txd;
    assign BUSY  = r_busy;
    assign DONE  = r_done;

endmodule

// File: tb/tb_rep3_tx.sv
// Bench for rep3_tx: two instances (1 and 4 clocks per chip) checked cycle by cycle
// against a chip-sequence reference derived from the frame format.
module tb_rep3_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid [2];
    logic [7:0] din   [2];
    logic       ready [2];
    logic       txd   [2];
    logic       busy  [2];
    logic       done  [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rep3_tx #(.DATA_W(8), .CLKS_PER_CHIP(1)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .DIN(din[0]), .VALID(valid[0]),
        .READY(ready[0]), .TXD(txd[0]), .BUSY(busy[0]), .DONE(done[0])
    );

    rep3_tx #(.DATA_W(8), .CLKS_PER_CHIP(4)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .DIN(din[1]), .VALID(valid[1]),
        .READY(ready[1]), .TXD(txd[1]), .BUSY(busy[1]), .DONE(done[1])
    );

    function automatic int cpc_of(int u);
        return (u == 0) ? 1 : 4;
    endfunction

    // Line level in frame cycle c (1-based): frame bits are start, d[0..7], stop,
    // each lasting 3 chips of cpc clocks.
    function automatic logic ref_level(logic [7:0] d, int c, int cpc);
        int b;
        b = (c - 1) / (3 * cpc);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_unit(int u, string what, logic e_txd, logic e_ready,
                              logic e_busy, logic e_done);
        check($sformatf("u%0d %s txd", u, what),   txd[u],   e_txd);
        check($sformatf("u%0d %s ready", u, what), ready[u], e_ready);
        check($sformatf("u%0d %s busy", u, what),  busy[u],  e_busy);
        check($sformatf("u%0d %s done", u, what),  done[u],  e_done);
    endtask

    task automatic idle(int n, string what);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid[0] = 1'b0;
            valid[1] = 1'b0;
            @(negedge clk);
            check_unit(0, what, 1'b1, 1'b1, 1'b0, 1'b0);
            check_unit(1, what, 1'b1, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Offers d on unit u and checks every cycle up to and including the DONE
    // cycle. Returns at the negedge of the DONE cycle with VALID=b2b, DIN=nd.
    // abort_at > 0 pulses RST_N low during that frame cycle instead.
    task automatic frame(int u, logic [7:0] d, bit scramble, bit b2b,
                         logic [7:0] nd, int abort_at);
        int len;
        len = 30 * cpc_of(u);
        din[u]   = d;
        valid[u] = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= len + 1; c++) begin
            if (c == len + 1) begin
                valid[u] = b2b;
                din[u]   = nd;
            end else if (scramble) begin
                valid[u] = 1'($urandom_range(0, 1));
                din[u]   = 8'($urandom);
            end else begin
                valid[u] = 1'b0;
            end
            if (c == abort_at) begin
                rst_n    = 1'b0;
                valid[u] = 1'b0;
            end
            @(negedge clk);
            if (c <= len)
                check_unit(u, $sformatf("d=%h c=%0d", d, c),
                           ref_level(d, c, cpc_of(u)), 1'b0, 1'b1, 1'b0);
            else
                check_unit(u, $sformatf("d=%h done", d), 1'b1, 1'b1, 1'b0, 1'b1);
            if (c == abort_at) begin
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                check_unit(u, "after abort", 1'b1, 1'b1, 1'b0, 1'b0);
                return;
            end
            if (c <= len) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        din[0]   = 8'h00;
        din[1]   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_unit(0, "in reset", 1'b1, 1'b1, 1'b0, 1'b0);
        check_unit(1, "in reset", 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(20, "post reset");

        frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, 0);
        idle(3, "gap a5");

        frame(1, 8'h01, 1'b0, 1'b0, 8'h00, 0);
        idle(3, "gap slow");

        frame(0, 8'hFF, 1'b0, 1'b1, 8'h00, 0);
        frame(0, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        idle(2, "gap b2b");

        frame(0, 8'h3C, 1'b1, 1'b0, 8'h00, 0);
        idle(2, "gap scramble");

        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            int         u;
            d = 8'($urandom);
            u = (i == 2) ? 1 : 0;
            frame(u, d, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 0);
            idle(2, "gap random");
        end

        // Frame cycle 14 lies inside data bit 3 (cycles 13..15 at one clock per chip).
        frame(0, 8'h96, 1'b0, 1'b0, 8'h00, 14);
        idle(40, "post abort");
        frame(0, 8'h6B, 1'b0, 1'b0, 8'h00, 0);
        idle(2, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
